vending_machine_gen: RTL and testbench

Parametrised next-generation vending controller. Supports N items with per-item prices and stock counters, multi-coin accumulation, cancel/refund and metered change return. A single coin strobe, coin_valid, replaces the old second clock. The block sits between the coin acceptor/keypad front end and the dispenser/change-hopper drivers.

---
 rtl/vm_pkg.sv | 34 +++
 rtl/vm_stock_table.sv | 57 +++++
 rtl/vending_machine_gen.sv | 212 +++++++++++++++++++++
 tb/tb_vending_machine_gen.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending controller: FSM state codes, item codes
// and the price lookup used by the controller.
package vm_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        VEND    = 3'd2,
        CHANGE  = 3'd3
    } vm_state_e;

    localparam int unsigned GRAPE     = 1;
    localparam int unsigned ORANGE    = 2;
    localparam int unsigned MANGO     = 3;
    localparam int unsigned PINEAPPLE = 4;

    // Price fields are 8 bits wide. A price can be larger than any single coin
    // (Pineapple costs 40, above the 5-bit coin range).
    localparam int unsigned PRICE_W     = 8;
    localparam int unsigned MAX_ITEMS   = 16;
    localparam int unsigned PRICE_VEC_W = MAX_ITEMS * PRICE_W;

    // Price of item 'code' (1-based); code 0 or out of range yields 0.
    function automatic logic [PRICE_W-1:0] price_of(input logic [PRICE_VEC_W-1:0] prices,
                                                    input int unsigned code);
        logic [PRICE_W-1:0] p;
        p = '0;
        if (code >= 1 && code <= MAX_ITEMS) begin
            p = prices[(code - 1) * PRICE_W +: PRICE_W];
        end
        return p;
    endfunction

endpackage

// File: rtl/vm_stock_table.sv
// Per-item stock counters.
// Ports: clk/rst (async, active high, loads INIT_STOCK), dec_i/dec_item_i
// (take one unit of an item), restock_i/restock_item_i/restock_qty_i
// (saturating add), sold_out_o (bit i-1 set when item i is empty).
module vm_stock_table #(
    parameter int unsigned NUM_ITEMS  = 4,
    parameter int unsigned ITEM_W     = 3,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned INIT_STOCK = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_i,
    input  logic [ITEM_W-1:0]    dec_item_i,
    input  logic                 restock_i,
    input  logic [ITEM_W-1:0]    restock_item_i,
    input  logic [STOCK_W-1:0]   restock_qty_i,
    output logic [NUM_ITEMS-1:0] sold_out_o
);

    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0] stock_d [NUM_ITEMS];
    logic [STOCK_W:0]   sum_c   [NUM_ITEMS];

    // Next count per item: decrement on vend, saturating add on restock.
    always_comb begin
        for (int i = 0; i < int'(NUM_ITEMS); i++) begin
            stock_d[i] = stock_q[i];
            sum_c[i]   = (STOCK_W+1)'(stock_q[i]) + (STOCK_W+1)'(restock_qty_i);
            if (dec_i && dec_item_i == ITEM_W'(i + 1) && stock_q[i] != '0) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            end else if (restock_i && restock_item_i == ITEM_W'(i + 1)) begin
                stock_d[i] = sum_c[i][STOCK_W] ? '1 : sum_c[i][STOCK_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_ITEMS); i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            for (int i = 0; i < int'(NUM_ITEMS); i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    // Pure decode of the counter flops.
    always_comb begin
        for (int i = 0; i < int'(NUM_ITEMS); i++) begin
            sold_out_o[i] = (stock_q[i] == '0);
        end
    end

endmodule

// File: rtl/vending_machine_gen.sv
// Vending controller: item selection, coin accumulation, vend, cancel/refund
// and metered change return.
// Ports: clk/rst (async, active high); item_sel, coin_valid, coin_val, cancel
// from the front end; restock/restock_item/restock_qty for service; dispense,
// dispense_item, change_valid, change_val, coin_reject to the drivers;
// balance, sold_out, state for status.
module vending_machine_gen
    import vm_pkg::*;
#(
    parameter int unsigned                   NUM_ITEMS  = 4,
    parameter int unsigned                   ITEM_W     = 3,
    parameter int unsigned                   VAL_W      = 5,
    parameter int unsigned                   BAL_W      = 7,
    parameter logic [NUM_ITEMS*PRICE_W-1:0]  PRICES     = {8'd40, 8'd25, 8'd30, 8'd20},
    parameter int unsigned                   STOCK_W    = 4,
    parameter int unsigned                   INIT_STOCK = 2,
    parameter int unsigned                   CHG_MAX    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ITEM_W-1:0]    item_sel,
    input  logic                 coin_valid,
    input  logic [VAL_W-1:0]     coin_val,
    input  logic                 cancel,
    input  logic                 restock,
    input  logic [ITEM_W-1:0]    restock_item,
    input  logic [STOCK_W-1:0]   restock_qty,
    output logic                 dispense,
    output logic [ITEM_W-1:0]    dispense_item,
    output logic                 change_valid,
    output logic [VAL_W-1:0]     change_val,
    output logic                 coin_reject,
    output logic [BAL_W-1:0]     balance,
    output logic [NUM_ITEMS-1:0] sold_out,
    output logic [2:0]           state
);

    // Arithmetic width wide enough for balance, price and coin plus a carry.
    localparam int unsigned MAX_AB = (BAL_W > PRICE_W) ? BAL_W : PRICE_W;
    localparam int unsigned SUM_W  = ((MAX_AB > VAL_W) ? MAX_AB : VAL_W) + 1;
    localparam logic [SUM_W-1:0]       BAL_MAX    = SUM_W'((64'd1 << BAL_W) - 64'd1);
    localparam logic [PRICE_VEC_W-1:0] PRICES_EXT = PRICE_VEC_W'(PRICES);

    vm_state_e          state_q, state_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic [ITEM_W-1:0]  item_q, item_d;
    logic               dispense_q, dispense_d;
    logic [ITEM_W-1:0]  dispense_item_q, dispense_item_d;
    logic               change_valid_q, change_valid_d;
    logic [VAL_W-1:0]   change_val_q, change_val_d;
    logic               coin_reject_q, coin_reject_d;

    logic [NUM_ITEMS-1:0] sold_out_w;
    logic                 sel_ok_c;
    logic                 coin_evt_c;
    logic [ITEM_W-1:0]    price_code_c;
    logic [SUM_W-1:0]     price_c;
    logic [SUM_W-1:0]     sum_c;
    logic [BAL_W-1:0]     rem_c;
    logic                 vend_dec_c;
    logic                 restock_ok_c;

    // One change word: the balance capped at CHG_MAX.
    function automatic logic [VAL_W-1:0] chg_word(input logic [BAL_W-1:0] bal);
        if (SUM_W'(bal) > SUM_W'(CHG_MAX)) begin
            return VAL_W'(CHG_MAX);
        end
        return VAL_W'(bal);
    endfunction

    // Selected item is a valid code with stock remaining.
    always_comb begin
        sel_ok_c = 1'b0;
        for (int i = 0; i < int'(NUM_ITEMS); i++) begin
            if (item_sel == ITEM_W'(i + 1) && !sold_out_w[i]) begin
                sel_ok_c = 1'b1;
            end
        end
    end

    assign vend_dec_c   = (state_q == VEND);
    assign restock_ok_c = restock && (state_q == IDLE);

    vm_stock_table #(
        .NUM_ITEMS  (NUM_ITEMS),
        .ITEM_W     (ITEM_W),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk            (clk),
        .rst            (rst),
        .dec_i          (vend_dec_c),
        .dec_item_i     (item_q),
        .restock_i      (restock_ok_c),
        .restock_item_i (restock_item),
        .restock_qty_i  (restock_qty),
        .sold_out_o     (sold_out_w)
    );

    // Next-state, balance and registered-output logic.
    always_comb begin
        state_d         = state_q;
        balance_d       = balance_q;
        item_d          = item_q;
        dispense_d      = 1'b0;
        dispense_item_d = '0;
        change_valid_d  = 1'b0;
        change_val_d    = '0;
        coin_reject_d   = 1'b0;
        rem_c           = '0;

        // A zero-valued coin strobe is dropped silently.
        coin_evt_c   = coin_valid && (coin_val != '0);
        price_code_c = (state_q == IDLE) ? item_sel : item_q;
        price_c      = SUM_W'(price_of(PRICES_EXT, 32'(price_code_c)));
        sum_c        = SUM_W'(balance_q) + SUM_W'(coin_val);

        unique case (state_q)
            IDLE: begin
                if (coin_evt_c) begin
                    if (sel_ok_c && sum_c <= BAL_MAX) begin
                        item_d    = item_sel;
                        balance_d = BAL_W'(sum_c);
                        state_d   = (sum_c >= price_c) ? VEND : COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (cancel) begin
                    state_d        = CHANGE;
                    change_valid_d = 1'b1;
                    change_val_d   = chg_word(balance_q);
                    coin_reject_d  = coin_evt_c;
                end else if (coin_evt_c) begin
                    if (sum_c <= BAL_MAX) begin
                        balance_d = BAL_W'(sum_c);
                        if (sum_c >= price_c) begin
                            state_d = VEND;
                        end
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_evt_c;
                rem_c         = balance_q - BAL_W'(price_c);
                balance_d     = rem_c;
                if (rem_c != '0) begin
                    state_d        = CHANGE;
                    change_valid_d = 1'b1;
                    change_val_d   = chg_word(rem_c);
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                // balance_q still includes the word on the bus this cycle.
                coin_reject_d = coin_evt_c;
                rem_c         = balance_q - BAL_W'(change_val_q);
                balance_d     = rem_c;
                if (rem_c != '0) begin
                    change_valid_d = 1'b1;
                    change_val_d   = chg_word(rem_c);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                balance_d = '0;
            end
        endcase

        dispense_d      = (state_d == VEND);
        dispense_item_d = dispense_d ? item_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            balance_q       <= '0;
            item_q          <= '0;
            dispense_q      <= 1'b0;
            dispense_item_q <= '0;
            change_valid_q  <= 1'b0;
            change_val_q    <= '0;
            coin_reject_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            balance_q       <= balance_d;
            item_q          <= item_d;
            dispense_q      <= dispense_d;
            dispense_item_q <= dispense_item_d;
            change_valid_q  <= change_valid_d;
            change_val_q    <= change_val_d;
            coin_reject_q   <= coin_reject_d;
        end
    end

    assign dispense      = dispense_q;
    assign dispense_item = dispense_item_q;
    assign change_valid  = change_valid_q;
    assign change_val    = change_val_q;
    assign coin_reject   = coin_reject_q;
    assign balance       = balance_q;
    assign sold_out      = sold_out_w;
    assign state         = state_q;

endmodule

// File: tb/tb_vending_machine_gen.sv
// Scoreboard bench for vending_machine_gen: expected dispense, change and
// reject events are queued with their cycle as stimulus is driven and popped
// by a monitor when the DUT produces them.
module tb_vending_machine_gen;
    import vm_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] item_sel = '0;
    logic       coin_valid = 1'b0;
    logic [4:0] coin_val = '0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic [2:0] restock_item = '0;
    logic [3:0] restock_qty = '0;
    logic       dispense;
    logic [2:0] dispense_item;
    logic       change_valid;
    logic [4:0] change_val;
    logic       coin_reject;
    logic [6:0] balance;
    logic [3:0] sold_out;
    logic [2:0] state;

    vending_machine_gen dut (
        .clk           (clk),
        .rst           (rst),
        .item_sel      (item_sel),
        .coin_valid    (coin_valid),
        .coin_val      (coin_val),
        .cancel        (cancel),
        .restock       (restock),
        .restock_item  (restock_item),
        .restock_qty   (restock_qty),
        .dispense      (dispense),
        .dispense_item (dispense_item),
        .change_valid  (change_valid),
        .change_val    (change_val),
        .coin_reject   (coin_reject),
        .balance       (balance),
        .sold_out      (sold_out),
        .state         (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int unsigned val;
        int unsigned cyc;
    } exp_t;

    exp_t        disp_q[$];
    exp_t        chg_q[$];
    exp_t        rej_q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_stock[4];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] exp_sold();
        logic [3:0] s;
        for (int i = 0; i < 4; i++) s[i] = (exp_stock[i] == 0);
        return s;
    endfunction

    // Scoreboard monitor: sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (dispense) begin
                n_cmp++;
                if (disp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL dispense_unexpected: item=%0d cyc=%0d, none queued", dispense_item, cyc);
                end else begin
                    e = disp_q.pop_front();
                    if (dispense_item !== 3'(e.val) || cyc !== e.cyc) begin
                        n_err++;
                        $display("FAIL dispense: got item=%0d cyc=%0d, need item=%0d cyc=%0d",
                                 dispense_item, cyc, e.val, e.cyc);
                    end
                end
            end
            if (change_valid) begin
                n_cmp++;
                if (chg_q.size() == 0) begin
                    n_err++;
                    $display("FAIL change_unexpected: val=%0d cyc=%0d, none queued", change_val, cyc);
                end else begin
                    e = chg_q.pop_front();
                    if (change_val !== 5'(e.val) || cyc !== e.cyc) begin
                        n_err++;
                        $display("FAIL change: got val=%0d cyc=%0d, need val=%0d cyc=%0d",
                                 change_val, cyc, e.val, e.cyc);
                    end
                end
            end
            if (coin_reject) begin
                n_cmp++;
                if (rej_q.size() == 0) begin
                    n_err++;
                    $display("FAIL reject_unexpected: cyc=%0d, none queued", cyc);
                end else begin
                    e = rej_q.pop_front();
                    if (cyc !== e.cyc) begin
                        n_err++;
                        $display("FAIL reject: got cyc=%0d, need cyc=%0d", cyc, e.cyc);
                    end
                end
            end
        end
    end

    // Stimulus helpers: each starts and ends 1 time unit after a rising edge.
    task automatic put_coin(input logic [2:0] sel, input logic [4:0] val);
        item_sel = sel; coin_val = val; coin_valid = 1'b1;
        @(posedge clk); #1;
        coin_valid = 1'b0; coin_val = '0; item_sel = '0;
    endtask

    task automatic put_cancel(input logic with_coin, input logic [4:0] val);
        cancel = 1'b1; coin_valid = with_coin; coin_val = val;
        @(posedge clk); #1;
        cancel = 1'b0; coin_valid = 1'b0; coin_val = '0;
    endtask

    task automatic do_restock(input logic [2:0] it, input logic [3:0] qty);
        restock = 1'b1; restock_item = it; restock_qty = qty;
        @(posedge clk); #1;
        restock = 1'b0; restock_item = '0; restock_qty = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) exp_stock[i] = 2;
        n_cmp++;
        if ({dispense, dispense_item, change_valid, change_val, coin_reject} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %0h, need 0",
                     {dispense, dispense_item, change_valid, change_val, coin_reject});
        end
        n_cmp++;
        if (balance !== 7'd0 || state !== 3'd0 || sold_out !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_status: got bal=%0d state=%0d sold=%b, need 0/0/0000", balance, state, sold_out);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_exact_orange();
        put_coin(3'(ORANGE), 5'd10);
        n_cmp++;
        if (state !== 3'd1 || balance !== 7'd10) begin
            n_err++;
            $display("FAIL orange_collect: got state=%0d bal=%0d, need 1/10", state, balance);
        end
        disp_q.push_back('{ORANGE, cyc + 1});
        put_coin(3'(ORANGE), 5'd20);
        n_cmp++;
        if (state !== 3'd2 || balance !== 7'd30) begin
            n_err++;
            $display("FAIL orange_vend: got state=%0d bal=%0d, need 2/30", state, balance);
        end
        idle(1);
        exp_stock[ORANGE-1]--;
        n_cmp++;
        if (state !== 3'd0 || balance !== 7'd0 || sold_out !== exp_sold()) begin
            n_err++;
            $display("FAIL orange_done: got state=%0d bal=%0d sold=%b, need 0/0/%b",
                     state, balance, sold_out, exp_sold());
        end
        n_cmp++;
        if (dut.u_stock.stock_q[ORANGE-1] !== 4'(exp_stock[ORANGE-1])) begin
            n_err++;
            $display("FAIL orange_stock: got %0d, need %0d", dut.u_stock.stock_q[ORANGE-1], exp_stock[ORANGE-1]);
        end
    endtask

    task automatic test_change();
        put_coin(3'(ORANGE), 5'd20);
        disp_q.push_back('{ORANGE, cyc + 1});
        chg_q.push_back('{10, cyc + 2});
        put_coin(3'(ORANGE), 5'd20);
        idle(2);
        exp_stock[ORANGE-1]--;
        n_cmp++;
        if (state !== 3'd0 || balance !== 7'd0 || sold_out !== exp_sold()) begin
            n_err++;
            $display("FAIL change_done: got state=%0d bal=%0d sold=%b, need 0/0/%b",
                     state, balance, sold_out, exp_sold());
        end
    endtask

    task automatic test_cancel();
        put_coin(3'(PINEAPPLE), 5'd10);
        chg_q.push_back('{10, cyc + 1});
        put_cancel(1'b0, 5'd0);
        idle(1);
        n_cmp++;
        if (state !== 3'd0 || balance !== 7'd0) begin
            n_err++;
            $display("FAIL cancel1_done: got state=%0d bal=%0d, need 0/0", state, balance);
        end
        put_coin(3'(PINEAPPLE), 5'd20);
        put_coin(3'(PINEAPPLE), 5'd15);
        n_cmp++;
        if (state !== 3'd1 || balance !== 7'd35) begin
            n_err++;
            $display("FAIL cancel2_collect: got state=%0d bal=%0d, need 1/35", state, balance);
        end
        chg_q.push_back('{10, cyc + 1});
        chg_q.push_back('{10, cyc + 2});
        chg_q.push_back('{10, cyc + 3});
        chg_q.push_back('{5,  cyc + 4});
        put_cancel(1'b0, 5'd0);
        idle(4);
        n_cmp++;
        if (state !== 3'd0 || balance !== 7'd0 || sold_out !== exp_sold()) begin
            n_err++;
            $display("FAIL cancel2_done: got state=%0d bal=%0d sold=%b, need 0/0/%b",
                     state, balance, sold_out, exp_sold());
        end
    endtask

    task automatic test_sold_out();
        for (int k = 0; k < 2; k++) begin
            disp_q.push_back('{GRAPE, cyc + 1});
            put_coin(3'(GRAPE), 5'd20);
            idle(1);
            exp_stock[GRAPE-1]--;
        end
        n_cmp++;
        if (sold_out !== exp_sold() || sold_out[0] !== 1'b1) begin
            n_err++;
            $display("FAIL grape_sold_out: got %b, need %b", sold_out, exp_sold());
        end
        rej_q.push_back('{0, cyc + 1});
        put_coin(3'(GRAPE), 5'd20);
        n_cmp++;
        if (state !== 3'd0 || balance !== 7'd0) begin
            n_err++;
            $display("FAIL grape_reject: got state=%0d bal=%0d, need 0/0", state, balance);
        end
        do_restock(3'(GRAPE), 4'd3);
        exp_stock[GRAPE-1] = 3;
        n_cmp++;
        if (sold_out !== exp_sold() || dut.u_stock.stock_q[GRAPE-1] !== 4'd3) begin
            n_err++;
            $display("FAIL restock: got sold=%b stock=%0d, need %b/3", sold_out, dut.u_stock.stock_q[GRAPE-1], exp_sold());
        end
        do_restock(3'(GRAPE), 4'd15);
        exp_stock[GRAPE-1] = 15;
        n_cmp++;
        if (dut.u_stock.stock_q[GRAPE-1] !== 4'd15) begin
            n_err++;
            $display("FAIL restock_sat: got %0d, need 15", dut.u_stock.stock_q[GRAPE-1]);
        end
    endtask

    task automatic test_reject();
        rej_q.push_back('{0, cyc + 1});
        put_coin(3'd0, 5'd10);
        put_coin(3'(MANGO), 5'd0);
        n_cmp++;
        if (state !== 3'd0 || balance !== 7'd0) begin
            n_err++;
            $display("FAIL reject_idle: got state=%0d bal=%0d, need 0/0", state, balance);
        end
        put_coin(3'(MANGO), 5'd20);
        disp_q.push_back('{MANGO, cyc + 1});
        chg_q.push_back('{10, cyc + 2});
        chg_q.push_back('{5,  cyc + 3});
        put_coin(3'(MANGO), 5'd20);
        idle(1);
        n_cmp++;
        if (state !== 3'd3) begin
            n_err++;
            $display("FAIL mango_change_state: got %0d, need 3", state);
        end
        rej_q.push_back('{0, cyc + 1});
        put_coin(3'(MANGO), 5'd10);
        idle(1);
        exp_stock[MANGO-1]--;
        n_cmp++;
        if (state !== 3'd0 || balance !== 7'd0) begin
            n_err++;
            $display("FAIL mango_done: got state=%0d bal=%0d, need 0/0", state, balance);
        end
        put_coin(3'(MANGO), 5'd10);
        chg_q.push_back('{10, cyc + 1});
        rej_q.push_back('{0, cyc + 1});
        item_sel = 3'(MANGO);
        put_cancel(1'b1, 5'd5);
        item_sel = '0;
        idle(1);
        n_cmp++;
        if (state !== 3'd0 || balance !== 7'd0 || dut.u_stock.stock_q[MANGO-1] !== 4'(exp_stock[MANGO-1])) begin
            n_err++;
            $display("FAIL cancel_coin: got state=%0d bal=%0d stock=%0d, need 0/0/%0d",
                     state, balance, dut.u_stock.stock_q[MANGO-1], exp_stock[MANGO-1]);
        end
    endtask

    task automatic test_reset_mid();
        put_coin(3'(PINEAPPLE), 5'd20);
        chg_q.push_back('{10, cyc + 1});
        put_cancel(1'b0, 5'd0);
        n_cmp++;
        if (state !== 3'd3 || balance !== 7'd20) begin
            n_err++;
            $display("FAIL pre_reset: got state=%0d bal=%0d, need 3/20", state, balance);
        end
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) exp_stock[i] = 2;
        n_cmp++;
        if ({dispense, dispense_item, change_valid, change_val, coin_reject} !== 11'd0
            || balance !== 7'd0 || state !== 3'd0) begin
            n_err++;
            $display("FAIL async_reset: got cv=%0d bal=%0d state=%0d, need 0/0/0", change_valid, balance, state);
        end
        n_cmp++;
        if (sold_out !== exp_sold() || dut.u_stock.stock_q[GRAPE-1] !== 4'd2
            || dut.u_stock.stock_q[ORANGE-1] !== 4'd2) begin
            n_err++;
            $display("FAIL reset_stock: got sold=%b grape=%0d orange=%0d, need %b/2/2",
                     sold_out, dut.u_stock.stock_q[GRAPE-1], dut.u_stock.stock_q[ORANGE-1], exp_sold());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        put_coin(3'(ORANGE), 5'd10);
        disp_q.push_back('{ORANGE, cyc + 1});
        put_coin(3'(ORANGE), 5'd20);
        idle(1);
        exp_stock[ORANGE-1]--;
        n_cmp++;
        if (state !== 3'd0 || balance !== 7'd0 || dut.u_stock.stock_q[ORANGE-1] !== 4'(exp_stock[ORANGE-1])) begin
            n_err++;
            $display("FAIL post_reset_buy: got state=%0d bal=%0d stock=%0d, need 0/0/%0d",
                     state, balance, dut.u_stock.stock_q[ORANGE-1], exp_stock[ORANGE-1]);
        end
    endtask

    task automatic test_drain();
        @(negedge clk); #1;
        n_cmp++;
        if (disp_q.size() != 0 || chg_q.size() != 0 || rej_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: left disp=%0d chg=%0d rej=%0d, need 0/0/0",
                     disp_q.size(), chg_q.size(), rej_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_exact_orange();
        test_change();
        test_cancel();
        test_sold_out();
        test_reject();
        test_reset_mid();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
